// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant/response bus between the fetch stage
// (master) and instruction memory (slave).
interface fetch_stage_if;
    logic [31:0] i_address;
    logic        i_read_enable;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_data_in;

    modport master (
        output i_address,
        output i_read_enable,
        input  i_gnt,
        input  i_rvalid,
        input  i_data_in
    );

    modport slave (
        input  i_address,
        input  i_read_enable,
        output i_gnt,
        output i_rvalid,
        output i_data_in
    );
endinterface

// File: rtl/fetch_stage.sv
// DLX instruction-fetch stage: owns the fetch PC, issues in-order reads to
// instruction memory, buffers returned words in a small queue and drives the
// IF/ID register. Redirects from ID/EX flush the queue; responses still in
// flight at a redirect are counted and discarded when they arrive.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    fetch_stage_if.master      imem,
    input  logic               stall_ID,
    input  logic               Pc_cmd_id,
    input  logic [31:0]        pc_in_ID,
    input  logic               pc_cmd_EX,
    input  logic [31:0]        pc_target_EX,
    output logic [31:0]        i_data_read,
    output logic [31:0]        PC_ID,
    output logic               valid_ID
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    // Circular-pointer increment that also handles non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_P) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Fetch PC and queue bookkeeping. Entries are filled strictly in order,
    // so the filled entries always form a prefix of the queue: the head is
    // filled exactly when allocated > unfilled.
    logic [31:0]   f_pc_q, f_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] fill_ptr_q, fill_ptr_d;
    logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0] unf_cnt_q, unf_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    // Queue payload storage (no reset needed: only read once allocated/filled).
    logic [31:0] pc_mem_q   [DEPTH];
    logic [31:0] data_mem_q [DEPTH];

    // IF/ID register.
    logic        valid_q, valid_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] pcid_q, pcid_d;

    // Per-cycle decisions.
    logic          redirect;
    logic [31:0]   target;
    logic [CW:0]   occupancy;
    logic          req;
    logic          grant;
    logic          resp_drop;
    logic          resp_fill;
    logic          head_filled;
    logic          head_bypass;
    logic          pop;
    logic [31:0]   head_data;

    // Issue, response and IF/ID-advance decisions for this cycle.
    always_comb begin
        redirect    = pc_cmd_EX | Pc_cmd_id;
        target      = pc_cmd_EX ? pc_target_EX : pc_in_ID;
        occupancy   = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
        req         = !reset && (occupancy < DEPTH_C) && !redirect;
        grant       = req && imem.i_gnt;
        resp_drop   = imem.i_rvalid && (drop_cnt_q != '0);
        resp_fill   = imem.i_rvalid && (drop_cnt_q == '0) && (unf_cnt_q != '0);
        head_filled = (alloc_cnt_q != unf_cnt_q);
        // With no filled entries the oldest unfilled entry is the head itself.
        head_bypass = !head_filled && resp_fill;
        pop         = !redirect && !stall_ID && (head_filled || head_bypass);
        head_data   = head_filled ? data_mem_q[rd_ptr_q] : imem.i_data_in;
    end

    assign imem.i_address     = f_pc_q;
    assign imem.i_read_enable = req;
    assign i_data_read        = insn_q;
    assign PC_ID              = pcid_q;
    assign valid_ID           = valid_q;

    // Next-state for PC, queue counters/pointers and the IF/ID register.
    always_comb begin
        f_pc_d      = f_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        alloc_cnt_d = alloc_cnt_q;
        unf_cnt_d   = unf_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        valid_d     = valid_q;
        insn_d      = insn_q;
        pcid_d      = pcid_q;

        if (redirect) begin
            // Everything still outstanding after this cycle's response
            // (which is itself discarded) must be dropped when it returns.
            f_pc_d      = target;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            fill_ptr_d  = '0;
            alloc_cnt_d = '0;
            unf_cnt_d   = '0;
            drop_cnt_d  = drop_cnt_q + unf_cnt_q
                          - CW'(resp_drop || resp_fill);
            valid_d     = 1'b0;
            insn_d      = NOP_INSN;
        end else begin
            if (grant) begin
                f_pc_d   = f_pc_q + 32'd4;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (resp_fill) begin
                fill_ptr_d = ptr_inc(fill_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            alloc_cnt_d = alloc_cnt_q + CW'(grant) - CW'(pop);
            unf_cnt_d   = unf_cnt_q + CW'(grant) - CW'(resp_fill);
            drop_cnt_d  = drop_cnt_q - CW'(resp_drop);

            if (!stall_ID) begin
                if (pop) begin
                    valid_d = 1'b1;
                    insn_d  = head_data;
                    pcid_d  = pc_mem_q[rd_ptr_q];
                end else begin
                    valid_d = 1'b0;
                    insn_d  = NOP_INSN;
                end
            end
        end
    end

    // Control and IF/ID state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q      <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fill_ptr_q  <= '0;
            alloc_cnt_q <= '0;
            unf_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            valid_q     <= 1'b0;
            insn_q      <= NOP_INSN;
            pcid_q      <= 32'h0000_0000;
        end else begin
            f_pc_q      <= f_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            alloc_cnt_q <= alloc_cnt_d;
            unf_cnt_q   <= unf_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            valid_q     <= valid_d;
            insn_q      <= insn_d;
            pcid_q      <= pcid_d;
        end
    end

    // Queue payload writes: PC at grant, instruction word at response.
    always_ff @(posedge clk) begin
        if (grant) begin
            pc_mem_q[wr_ptr_q] <= f_pc_q;
        end
        if (resp_fill) begin
            data_mem_q[fill_ptr_q] <= imem.i_data_in;
        end
    end

endmodule
